sprite_grid_renderer: RTL and testbench

SPRITE_GRID_RENDERER -- requirements
Module: sprite_grid_renderer

---
 rtl/sprite_grid_renderer_pkg.sv | 30 +++
 rtl/sprite_grid_renderer_sprite_rom.sv | 50 +++++
 rtl/sprite_grid_renderer.sv | 144 ++++++++++++++
 tb/tb_sprite_grid_renderer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sprite_grid_renderer_pkg.sv
// Shared constants, state encoding and sprite type indices for the sprite grid renderer.
package sprite_grid_renderer_pkg;

  localparam int SPR_W     = 13;
  localparam int SPR_H     = 8;
  localparam int NUM_TYPES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SCAN,
    S_NEXT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SPR_CRAB    = 2'd0,
    SPR_SQUID   = 2'd1,
    SPR_OCTOPUS = 2'd2,
    SPR_CANNON  = 2'd3
  } spr_type_t;

  // Alien rows cycle through the three alien shapes.
  function automatic spr_type_t alien_type(input logic [2:0] row);
    logic [2:0] m;
    m = row % 3'd3;
    return spr_type_t'(m[1:0]);
  endfunction

endpackage

// File: rtl/sprite_grid_renderer_sprite_rom.sv
// Combinational sprite bitmap ROM: one 13-pixel row per (type, row); bit 0 is the leftmost pixel.
module sprite_rom
  import sprite_grid_renderer_pkg::*;
(
  input  logic [1:0]       sprite_type,
  input  logic [2:0]       row,
  output logic [SPR_W-1:0] bits
);

  always_comb begin
    // NOTE: default assigned first so no path through the case can infer a latch.
    bits = '0;
    case ({sprite_type, row})
      5'b00_000: bits = 13'b0001000001000;
      5'b00_001: bits = 13'b0000100010000;
      5'b00_010: bits = 13'b0001111111000;
      5'b00_011: bits = 13'b0011011101100;
      5'b00_100: bits = 13'b0111111111110;
      5'b00_101: bits = 13'b0101111111010;
      5'b00_110: bits = 13'b0101000001010;
      5'b00_111: bits = 13'b0000110110000;
      5'b01_000: bits = 13'b0000011100000;
      5'b01_001: bits = 13'b0000111110000;
      5'b01_010: bits = 13'b0001111111000;
      5'b01_011: bits = 13'b0011011101100;
      5'b01_100: bits = 13'b0011111111100;
      5'b01_101: bits = 13'b0000100010000;
      5'b01_110: bits = 13'b0001011101000;
      5'b01_111: bits = 13'b0010100010100;
      5'b10_000: bits = 13'b0000111110000;
      5'b10_001: bits = 13'b0011111111100;
      5'b10_010: bits = 13'b0111111111110;
      5'b10_011: bits = 13'b0111001001110;
      5'b10_100: bits = 13'b0111111111110;
      5'b10_101: bits = 13'b0001100011000;
      5'b10_110: bits = 13'b0011011101100;
      5'b10_111: bits = 13'b0110000000110;
      5'b11_000: bits = 13'b0000001000000;
      5'b11_001: bits = 13'b0000011100000;
      5'b11_010: bits = 13'b0000011100000;
      5'b11_011: bits = 13'b0111111111110;
      5'b11_100: bits = 13'b1111111111111;
      5'b11_101: bits = 13'b1111111111111;
      5'b11_110: bits = 13'b1111111111111;
      5'b11_111: bits = 13'b1111111111111;
      default:   bits = '0;
    endcase
  end

endmodule

// File: rtl/sprite_grid_renderer.sv
// Walks every alien of the grid and then the cannon, emitting one pixel per set sprite bit to a VGA plotter.
module sprite_grid_renderer
  import sprite_grid_renderer_pkg::*;
#(
  parameter int         COLS          = 5,
  parameter int         ROWS          = 3,
  parameter int         X_PITCH       = 18,
  parameter int         Y_PITCH       = 10,
  parameter logic [2:0] ALIEN_COLOUR  = 3'b010,
  parameter logic [2:0] CANNON_COLOUR = 3'b010
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 erase,
  input  logic [7:0]           alienX,
  input  logic [6:0]           alienY,
  input  logic [7:0]           cannonX,
  input  logic [6:0]           cannonY,
  input  logic [COLS*ROWS-1:0] alive,
  input  logic                 ready,
  output logic [7:0]           xOut,
  output logic [6:0]           yOut,
  output logic [2:0]           colourOut,
  output logic                 plot,
  output logic                 busy,
  output logic                 done
);

  localparam int N_ALIENS = COLS * ROWS;

  state_t           state, state_next;
  logic [2:0]       col, row;
  logic [3:0]       px;
  logic [2:0]       py;
  logic [7:0]       org_x;
  logic [6:0]       org_y;
  spr_type_t        spr_type;
  logic             erase_q;

  logic [SPR_W-1:0] rom_bits;
  logic [5:0]       ent_idx;
  logic             is_cannon, ent_alive, pix_set, advance, last_px, last_py, in_scan;

  sprite_rom u_rom (
    .sprite_type (spr_type),
    .row         (py),
    .bits        (rom_bits)
  );

  // The cannon sits one row past the last alien row, at column 0.
  assign is_cannon = (row == 3'(ROWS));
  assign ent_idx   = 6'(row * COLS + col);
  assign ent_alive = is_cannon || ((alive & (N_ALIENS'(1) << ent_idx)) != '0);
  assign pix_set   = rom_bits[px];
  assign advance   = !pix_set || ready;
  assign last_px   = (px == 4'(SPR_W - 1));
  assign last_py   = (py == 3'(SPR_H - 1));
  assign in_scan   = (state == S_SCAN);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_SETUP;
      S_SETUP: state_next = ent_alive ? S_SCAN : S_NEXT;
      S_SCAN:  if (advance && last_px && last_py) state_next = S_NEXT;
      S_NEXT:  state_next = is_cannon ? S_DONE : S_SETUP;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are forced to zero outside SCAN so the plotter never sees stale coordinates.
  always_comb begin
    plot      = in_scan && pix_set;
    xOut      = in_scan ? org_x + 8'(px) : 8'd0;
    yOut      = in_scan ? org_y + 7'(py) : 7'd0;
    colourOut = 3'b000;
    if (in_scan && !erase_q)
      colourOut = (spr_type == SPR_CANNON) ? CANNON_COLOUR : ALIEN_COLOUR;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col      <= '0;
      row      <= '0;
      px       <= '0;
      py       <= '0;
      org_x    <= '0;
      org_y    <= '0;
      spr_type <= SPR_CRAB;
      erase_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same clock edge.
      case (state)
        S_IDLE: if (start) begin
          col     <= '0;
          row     <= '0;
          px      <= '0;
          py      <= '0;
          erase_q <= erase;
        end
        S_SETUP: begin
          px <= '0;
          py <= '0;
          if (is_cannon) begin
            org_x    <= cannonX;
            org_y    <= cannonY;
            spr_type <= SPR_CANNON;
          end else begin
            org_x    <= alienX + 8'(col * X_PITCH);
            org_y    <= alienY + 7'(row * Y_PITCH);
            spr_type <= alien_type(row);
          end
        end
        S_SCAN: if (advance) begin
          if (last_px) begin
            px <= '0;
            py <= last_py ? 3'd0 : py + 3'd1;
          end else begin
            px <= px + 4'd1;
          end
        end
        S_NEXT: begin
          if (col == 3'(COLS - 1)) begin
            col <= '0;
            row <= row + 3'd1;
          end else begin
            col <= col + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_grid_renderer.sv
// Randomised self-checking bench: a frame-level model predicts the ordered list of accepted pixels and the pass length.
module tb_sprite_grid_renderer;

  localparam int COLS = 5;
  localparam int ROWS = 3;
  localparam int NA   = COLS * ROWS;
  localparam int W    = 13;
  localparam int H    = 8;

  // Sprite bitmaps, index type*8 + row, bit 0 = leftmost pixel.
  localparam logic [12:0] BMP [32] = '{
    13'b0001000001000, 13'b0000100010000, 13'b0001111111000, 13'b0011011101100,
    13'b0111111111110, 13'b0101111111010, 13'b0101000001010, 13'b0000110110000,
    13'b0000011100000, 13'b0000111110000, 13'b0001111111000, 13'b0011011101100,
    13'b0011111111100, 13'b0000100010000, 13'b0001011101000, 13'b0010100010100,
    13'b0000111110000, 13'b0011111111100, 13'b0111111111110, 13'b0111001001110,
    13'b0111111111110, 13'b0001100011000, 13'b0011011101100, 13'b0110000000110,
    13'b0000001000000, 13'b0000011100000, 13'b0000011100000, 13'b0111111111110,
    13'b1111111111111, 13'b1111111111111, 13'b1111111111111, 13'b1111111111111
  };

  logic          clock = 1'b0;
  logic          reset, start, erase, ready;
  logic [7:0]    alienX, cannonX, xOut;
  logic [6:0]    alienY, cannonY, yOut;
  logic [NA-1:0] alive;
  logic [2:0]    colourOut;
  logic          plot, busy, done;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [17:0]   exp_q [$];
  int            exp_cycles;
  logic [17:0]   first_acc;
  bit            got_first;
  int            pass_cycles;

  always #5 clock = ~clock;

  sprite_grid_renderer dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .erase     (erase),
    .alienX    (alienX),
    .alienY    (alienY),
    .cannonX   (cannonX),
    .cannonY   (cannonY),
    .alive     (alive),
    .ready     (ready),
    .xOut      (xOut),
    .yOut      (yOut),
    .colourOut (colourOut),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Frame model: ordered accepted pixels {x,y,colour} and cycle count with ready held high.
  task automatic build_expected();
    int t, ox, oy;
    logic [2:0] col;
    exp_q.delete();
    exp_cycles = 1;
    for (int e = 0; e <= NA; e++) begin
      if (e < NA && !alive[e]) begin
        exp_cycles += 2;
        continue;
      end
      if (e < NA) begin
        t  = (e / COLS) % 3;
        ox = alienX + (e % COLS) * 18;
        oy = alienY + (e / COLS) * 10;
      end else begin
        t  = 3;
        ox = cannonX;
        oy = cannonY;
      end
      col = erase ? 3'b000 : 3'b010;
      exp_cycles += W * H + 2;
      for (int py = 0; py < H; py++)
        for (int px = 0; px < W; px++)
          if (BMP[t*8 + py][px])
            exp_q.push_back({8'(ox + px), 7'(oy + py), col});
    end
  endtask

  // rmode: 0 ready high, 1 toggling, 2 random.
  task automatic run_pass(input int rmode, input bit poke_start);
    int          cyc;
    bit          seen_done, prev_hold, tog;
    logic [17:0] cur, prev_pix;
    build_expected();
    got_first = 0;
    @(posedge clock);
    #1 start = 1'b1;
    cyc = 0; seen_done = 0; prev_hold = 0; tog = 0; prev_pix = '0;
    while (!seen_done && cyc < 8000) begin
      @(negedge clock);
      case (rmode)
        0:       ready = 1'b1;
        1:       begin ready = tog; tog = !tog; end
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (done) begin
        seen_done = 1;
      end else begin
        cur = {xOut, yOut, colourOut};
        if (prev_hold) begin
          check("hold_plot", plot, 1);
          check("hold_pixel", cur, prev_pix);
        end
        if (plot && ready) begin
          if (!got_first) begin first_acc = cur; got_first = 1; end
          check("pixel", 32'(cur), exp_q.size() > 0 ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF);
        end
        prev_hold = plot && !ready;
        prev_pix  = cur;
        @(posedge clock);
        cyc++;
        #1 start = poke_start && ($urandom_range(0, 39) == 0);
      end
    end
    // A start seen while DONE is showing must not launch another pass.
    start = poke_start;
    pass_cycles = cyc;
    check("done_seen", seen_done, 1);
    if (rmode == 0) check("pass_len", cyc, exp_cycles);
    check("pixels_left", exp_q.size(), 0);
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    check("done_pulse", done, 0);
    check("idle_after", busy, 0);
    repeat (3) @(negedge clock);
    check("no_queued_start", busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; erase = 1'b0; ready = 1'b1;
    alienX = 8'd10; alienY = 7'd5; cannonX = 8'd60; cannonY = 7'd100;
    alive = '1;
    #1;
    check("reset_outs", {xOut, yOut, colourOut, plot, busy, done}, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Default grid, everything alive, ready held high.
    run_pass(0, 0);
    check("first_x", first_acc[17:10], 13);
    check("first_y", first_acc[9:3], 5);
    check("len_all_alive", pass_cycles, 1697);

    // Only the cannon.
    alive = '0;
    run_pass(0, 0);
    check("len_cannon_only", pass_cycles, 137);

    // Back-pressure: ready toggling every cycle.
    alive = '1;
    run_pass(1, 0);

    // Horizontal wrap-around of the grid.
    alienX = 8'd250;
    run_pass(0, 0);
    check("len_wrap", pass_cycles, 1697);

    // Erase pass with spurious start pulses and random back-pressure.
    alienX = 8'd10;
    erase  = 1'b1;
    run_pass(2, 1);
    erase  = 1'b0;

    // Reset in the middle of a scan aborts the pass.
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (250) @(posedge clock);
    @(negedge clock);
    check("busy_before_reset", busy, 1);
    #2 reset = 1'b1;
    #1 check("reset_mid_outs", {xOut, yOut, colourOut, plot, busy, done}, 0);
    repeat (3) begin
      @(negedge clock);
      check("no_done_in_reset", done, 0);
    end
    reset = 1'b0;
    run_pass(0, 0);
    check("first_x_after_reset", first_acc[17:10], 13);

    // Random frames.
    for (int i = 0; i < 5; i++) begin
      alive   = NA'($urandom);
      alienX  = 8'($urandom);
      alienY  = 7'($urandom);
      cannonX = 8'($urandom);
      cannonY = 7'($urandom);
      erase   = 1'($urandom_range(0, 1));
      run_pass(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
